max_pool_layer: RTL

- 2x2, stride-2 max-pooling stage directly downstream of convolution_layer.
- Consumes the EngineCount parallel output streams (conv_valid_o / data_o) of the conv layer. Each stream is a row-major square feature map of width N.
- Emits floor(N/2)^2 pooled values per engine in row-major order.
- Uses a single half-width line buffer per engine; no full-frame storage.

---
 rtl/max_pool_layer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/max_pool_layer.sv
// 2x2 stride-2 max pooling over EngineCount parallel row-major feature maps, one half-width line buffer per engine.
// Optional fused ReLU on every pooled result when MAX_POOL_RELU_EN is defined.
module max_pool_layer #(
    parameter int Bits          = 8,
    parameter int EngineCount   = 2,
    parameter int MaxMatrixSize = 10
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   start_i,
    input  logic [$clog2(MaxMatrixSize+1)-1:0]     matrix_size_i,
    input  logic                                   data_valid_i,
    input  logic [EngineCount-1:0][Bits-1:0]       data_i,
    output logic                                   pool_valid_o,
    output logic [EngineCount-1:0][Bits-1:0]       data_o,
    output logic                                   pool_done_o,
    output logic                                   pool_running_o,
    input  logic                                   assert_on_i
);
    localparam int SW  = $clog2(MaxMatrixSize + 1);
    localparam int LBD = (MaxMatrixSize / 2 > 0) ? MaxMatrixSize / 2 : 1;
    localparam int LBW = (LBD > 1) ? $clog2(LBD) : 1;
    localparam logic [SW-1:0] ONE = SW'(1);
    localparam logic [SW-1:0] TWO = SW'(2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   n_reg, n_next;
    logic [SW-1:0]   c_reg, c_next;
    logic [SW-1:0]   r_reg, r_next;
    logic            valid_reg, done_reg;

    logic [SW-1:0]   n_m1, n_even;
    logic [LBW-1:0]  lb_addr;
    logic            beat, last_beat, in_window;
    logic            hold_wr, lb_wr, pool_fire, done_next;

    assign n_m1      = n_reg - ONE;
    assign n_even    = {n_reg[SW-1:1], 1'b0};
    assign beat      = (state_reg == RUN) && data_valid_i;
    assign last_beat = beat && (c_reg == n_m1) && (r_reg == n_m1);
    // The trailing row/column of an odd-sized map never belongs to a full window.
    assign in_window = (c_reg < n_even) && (r_reg < n_even);
    assign hold_wr   = beat && in_window && !c_reg[0];
    assign lb_wr     = beat && in_window && !r_reg[0] && c_reg[0];
    assign pool_fire = beat && in_window &&  r_reg[0] && c_reg[0];
    assign done_next = last_beat ||
                       ((state_reg == IDLE) && start_i && (matrix_size_i < TWO));
    assign lb_addr   = LBW'(c_reg >> 1);

    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        c_next     = c_reg;
        r_next     = r_reg;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    n_next = matrix_size_i;
                    c_next = '0;
                    r_next = '0;
                    if (matrix_size_i >= TWO)
                        state_next = RUN;
                end
            end
            RUN: begin
                if (beat) begin
                    if (c_reg == n_m1) begin
                        c_next = '0;
                        r_next = r_reg + ONE;
                    end else begin
                        c_next = c_reg + ONE;
                    end
                    if (last_beat) begin
                        state_next = IDLE;
                        c_next     = '0;
                        r_next     = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            c_reg     <= '0;
            r_reg     <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            c_reg     <= c_next;
            r_reg     <= r_next;
            valid_reg <= pool_fire;
            done_reg  <= done_next;
        end
    end

    assign pool_valid_o   = valid_reg;
    assign pool_done_o    = done_reg;
    assign pool_running_o = (state_reg == RUN);

    for (genvar gi = 0; gi < EngineCount; gi++) begin : g_engine
        logic signed [Bits-1:0] din, hold_reg, lb_rd, pair_max, win_max, result, data_reg;
        logic        [Bits-1:0] linebuf [LBD];

        assign din      = data_i[gi];
        assign lb_rd    = linebuf[lb_addr];
        assign pair_max = (din > hold_reg) ? din : hold_reg;
        assign win_max  = (pair_max > lb_rd) ? pair_max : lb_rd;
`ifdef MAX_POOL_RELU_EN
        assign result   = win_max[Bits-1] ? '0 : win_max;
`else
        assign result   = win_max;
`endif

        always_ff @(posedge clk_i) begin
            if (lb_wr)
                linebuf[lb_addr] <= pair_max;
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                hold_reg <= '0;
                data_reg <= '0;
            end else begin
                if (hold_wr)
                    hold_reg <= din;
                if (pool_fire)
                    data_reg <= result;
            end
        end

        assign data_o[gi] = data_reg;
    end

    // Simulation-only protocol checks, gated by assert_on_i.
    always @(posedge clk_i) begin
        if (!rst_i && assert_on_i && (state_reg == IDLE)) begin
            assert (!data_valid_i)
                else $error("max_pool_layer: data_valid_i asserted while IDLE");
            assert (!(start_i && (matrix_size_i > SW'(MaxMatrixSize))))
                else $error("max_pool_layer: matrix_size_i exceeds MaxMatrixSize");
        end
    end
endmodule
